// File: rtl/apb_ram_ws_slave_pkg.sv
// Shared APB definitions: bus widths, FSM state encoding and a byte-lane merge helper.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_STRB_WIDTH = 4;
    localparam int APB_PROT_WIDTH = 3;
    localparam int PROT_PRIV      = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    function automatic logic [APB_DATA_WIDTH-1:0] merge_bytes(
        input logic [APB_DATA_WIDTH-1:0] old_word,
        input logic [APB_DATA_WIDTH-1:0] new_word,
        input logic [APB_STRB_WIDTH-1:0] strb
    );
        logic [APB_DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < APB_STRB_WIDTH; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_ram_ws_slave_if.sv
// APB4 bus bundle between the requester and the wait-state RAM completer.
interface apb_ram_ws_slave_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_WIDTH-1:0]     paddr;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic [APB_STRB_WIDTH-1:0] pstrb;
    logic [APB_PROT_WIDTH-1:0] pprot;
    logic                      pready;
    logic                      pslverr;
    logic [APB_DATA_WIDTH-1:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_ram_ws_slave_mem.sv
// Single-port word RAM with per-byte write enables and a registered, clearable read port.
module apb_ram_ws_mem
    import apb_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IDX_W-1:0]          addr,
    input  logic                      wr_en,
    input  logic [APB_STRB_WIDTH-1:0] wr_strb,
    input  logic [APB_DATA_WIDTH-1:0] wr_data,
    input  logic                      rd_en,
    input  logic                      rd_clr,
    output logic [APB_DATA_WIDTH-1:0] rd_data
);
    logic [APB_DATA_WIDTH-1:0] mem_r [DEPTH];

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[addr] <= merge_bytes(mem_r[addr], wr_data, wr_strb);
        end
    end

    // Read register: an erroring read loads zero instead of the array word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 32'h0000_0000;
        end else if (rd_en) begin
            rd_data <= rd_clr ? 32'h0000_0000 : mem_r[addr];
        end else begin
            rd_data <= rd_data;
        end
    end
endmodule

// File: rtl/apb_ram_ws_slave.sv
// APB4 RAM completer with programmable wait states, byte strobes and PSLVERR on
// misaligned, out-of-range or unprivileged accesses.
module apb_ram_ws_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 2,
    parameter int PROT_WORDS  = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    apb_ram_ws_slave_if.slave     apb
);
    localparam int                    IDX_W     = $clog2(MEM_DEPTH);
    localparam int                    PRIV_BASE = MEM_DEPTH - PROT_WORDS;
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);
    localparam logic [3:0]            WS_INIT   = 4'(WAIT_STATES);

    apb_state_e                state_r;
    logic [3:0]                cnt_r;
    logic                      wr_r;
    logic                      err_r;
    logic [IDX_W-1:0]          idx_r;
    logic [DATA_WIDTH-1:0]     wdata_r;
    logic [APB_STRB_WIDTH-1:0] strb_r;
    logic                      pready_r;
    logic                      pslverr_r;

    logic             setup_s;
    logic             err_s;
    logic [IDX_W-1:0] idx_s;
    logic             done_next_s;
    logic             err_next_s;
    logic             complete_s;
    logic             mem_rd_s;
    logic             mem_wr_s;
    logic [IDX_W-1:0] mem_addr_s;

    // Address decode for the transfer currently presented in its setup phase.
    always_comb begin
        idx_s = apb.paddr[IDX_W+1:2];
        err_s = 1'b0;
        if (apb.paddr[1:0] != 2'b00) begin
            err_s = 1'b1;
        end else if (apb.paddr >= MEM_BYTES) begin
            err_s = 1'b1;
        end else if ((32'(idx_s) >= 32'(PRIV_BASE)) && !apb.pprot[PROT_PRIV]) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // done_next_s marks the edge before the completion cycle; the RAM read is
    // issued on that edge so PRDATA lands together with PREADY.
    always_comb begin
        setup_s     = (state_r == IDLE) && apb.psel && !apb.penable;
        complete_s  = (state_r == ACCESS) && apb.psel && (cnt_r == 4'd0);
        done_next_s = 1'b0;
        err_next_s  = 1'b0;
        mem_rd_s    = 1'b0;
        mem_addr_s  = idx_r;
        if (setup_s) begin
            done_next_s = (WS_INIT == 4'd0);
            err_next_s  = err_s;
            mem_rd_s    = (WS_INIT == 4'd0) && !apb.pwrite;
            mem_addr_s  = idx_s;
        end else begin
            done_next_s = (state_r == ACCESS) && apb.psel && (cnt_r == 4'd1);
            err_next_s  = err_r;
            mem_rd_s    = done_next_s && !wr_r;
            mem_addr_s  = idx_r;
        end
        mem_wr_s = complete_s && wr_r && !err_r;
    end

    // Transfer FSM, wait counter and registered handshake outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            wr_r      <= 1'b0;
            err_r     <= 1'b0;
            idx_r     <= '0;
            wdata_r   <= '0;
            strb_r    <= 4'h0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
        end else begin
            pready_r  <= done_next_s;
            pslverr_r <= done_next_s && err_next_s;
            case (state_r)
                IDLE: begin
                    if (setup_s) begin
                        state_r <= ACCESS;
                        cnt_r   <= WS_INIT;
                        wr_r    <= apb.pwrite;
                        err_r   <= err_s;
                        idx_r   <= idx_s;
                        wdata_r <= apb.pwdata;
                        strb_r  <= apb.pstrb;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!apb.psel) begin
                        state_r <= IDLE;
                        cnt_r   <= 4'd0;
                    end else if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    apb_ram_ws_mem #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .addr    (mem_addr_s),
        .wr_en   (mem_wr_s),
        .wr_strb (strb_r),
        .wr_data (wdata_r),
        .rd_en   (mem_rd_s),
        .rd_clr  (err_next_s),
        .rd_data (apb.prdata)
    );

    assign apb.pready  = pready_r;
    assign apb.pslverr = pslverr_r;
endmodule

// File: tb/tb_apb_ram_ws_slave.sv
// Directed bench for apb_ram_ws_slave: one instance with WAIT_STATES=2, one with 0.
module tb_apb_ram_ws_slave;
    logic PCLK = 1'b0;
    logic PRESETn;
    always #5 PCLK = ~PCLK;

    apb_ram_ws_slave_if #(.ADDR_WIDTH(32)) bus2 ();
    apb_ram_ws_slave_if #(.ADDR_WIDTH(32)) bus0 ();

    logic        sel0;
    logic        m_psel, m_penable, m_pwrite;
    logic [31:0] m_paddr, m_pwdata;
    logic [3:0]  m_pstrb;
    logic [2:0]  m_pprot;

    assign bus2.psel    = m_psel & ~sel0;
    assign bus0.psel    = m_psel & sel0;
    assign bus2.penable = m_penable;
    assign bus0.penable = m_penable;
    assign bus2.pwrite  = m_pwrite;
    assign bus0.pwrite  = m_pwrite;
    assign bus2.paddr   = m_paddr;
    assign bus0.paddr   = m_paddr;
    assign bus2.pwdata  = m_pwdata;
    assign bus0.pwdata  = m_pwdata;
    assign bus2.pstrb   = m_pstrb;
    assign bus0.pstrb   = m_pstrb;
    assign bus2.pprot   = m_pprot;
    assign bus0.pprot   = m_pprot;

    wire        s_pready  = sel0 ? bus0.pready  : bus2.pready;
    wire        s_pslverr = sel0 ? bus0.pslverr : bus2.pslverr;
    wire [31:0] s_prdata  = sel0 ? bus0.prdata  : bus2.prdata;

    apb_ram_ws_slave #(.WAIT_STATES(2)) dut_ws2 (.PCLK(PCLK), .PRESETn(PRESETn), .apb(bus2));
    apb_ram_ws_slave #(.WAIT_STATES(0)) dut_ws0 (.PCLK(PCLK), .PRESETn(PRESETn), .apb(bus0));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot,
                            output logic [31:0] rdata, output logic slverr,
                            output int cycles, output logic setup_rdy);
        @(posedge PCLK); #1;
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr;
        m_paddr = addr; m_pwdata = wdata; m_pstrb = strb; m_pprot = prot;
        setup_rdy = s_pready;
        @(posedge PCLK); #1;
        m_penable = 1'b1;
        cycles = 1;
        while (!s_pready && cycles < 20) begin
            @(posedge PCLK); #1;
            cycles++;
        end
        rdata  = s_prdata;
        slverr = s_pslverr;
    endtask

    task automatic go_idle(input string tag);
        @(posedge PCLK); #1;
        m_psel = 1'b0; m_penable = 1'b0;
        check_val(tag, {31'd0, s_pready}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        err;
    logic        srdy;
    int          cyc;

    initial begin
        PRESETn = 1'b0; sel0 = 1'b0;
        m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
        m_paddr = 32'h0; m_pwdata = 32'h0; m_pstrb = 4'h0; m_pprot = 3'b000;
        #1;
        check_val("rst_pready",  {31'd0, s_pready},  32'd0);
        check_val("rst_pslverr", {31'd0, s_pslverr}, 32'd0);
        check_val("rst_prdata",  s_prdata,           32'h0);
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;

        // Write then read with two wait states
        apb_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b001, rd, err, cyc, srdy);
        check_val("wr10_latency", cyc, 32'd3);
        check_val("wr10_slverr", {31'd0, err}, 32'd0);
        go_idle("wr10_pready_one_cycle");
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b001, rd, err, cyc, srdy);
        check_val("rd10_latency", cyc, 32'd3);
        check_val("rd10_data", rd, 32'hDEADBEEF);
        check_val("rd10_slverr", {31'd0, err}, 32'd0);
        go_idle("rd10_pready_one_cycle");

        // Reset in the middle of a write access
        @(posedge PCLK); #1;
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1;
        m_paddr = 32'h10; m_pwdata = 32'hCAFEF00D; m_pstrb = 4'hF; m_pprot = 3'b001;
        @(posedge PCLK); #1;
        m_penable = 1'b1;
        #2 PRESETn = 1'b0;
        #1;
        check_val("midrst_pready",  {31'd0, s_pready},  32'd0);
        check_val("midrst_pslverr", {31'd0, s_pslverr}, 32'd0);
        check_val("midrst_prdata",  s_prdata,           32'h0);
        m_psel = 1'b0; m_penable = 1'b0;
        @(posedge PCLK); #1 PRESETn = 1'b1;
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b001, rd, err, cyc, srdy);
        check_val("midrst_no_commit", rd, 32'hDEADBEEF);
        go_idle("midrst_idle");

        // Byte strobes
        apb_xfer(1'b1, 32'h10, 32'h11223344, 4'b0101, 3'b001, rd, err, cyc, srdy);
        go_idle("strb_wr_idle");
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b001, rd, err, cyc, srdy);
        check_val("strb_data", rd, 32'hDE22BE44);
        go_idle("strb_rd_idle");

        // Error responses
        apb_xfer(1'b0, 32'h12, 32'h0, 4'h0, 3'b001, rd, err, cyc, srdy);
        check_val("misalign_slverr", {31'd0, err}, 32'd1);
        check_val("misalign_prdata", rd, 32'h0);
        go_idle("misalign_idle");
        apb_xfer(1'b1, 32'h100, 32'h77777777, 4'hF, 3'b001, rd, err, cyc, srdy);
        check_val("range_slverr", {31'd0, err}, 32'd1);
        check_val("range_latency", cyc, 32'd3);
        go_idle("range_idle");
        apb_xfer(1'b1, 32'hE0, 32'h12345678, 4'hF, 3'b001, rd, err, cyc, srdy);
        check_val("priv_wr_ok", {31'd0, err}, 32'd0);
        go_idle("priv_wr_idle");
        apb_xfer(1'b1, 32'hE0, 32'hA5A5A5A5, 4'hF, 3'b000, rd, err, cyc, srdy);
        check_val("unpriv_wr_slverr", {31'd0, err}, 32'd1);
        go_idle("unpriv_wr_idle");
        apb_xfer(1'b0, 32'hE0, 32'h0, 4'h0, 3'b001, rd, err, cyc, srdy);
        check_val("priv_rd_old_data", rd, 32'h12345678);
        check_val("priv_rd_slverr", {31'd0, err}, 32'd0);
        go_idle("priv_rd_idle");
        apb_xfer(1'b1, 32'hDC, 32'h000000DC, 4'hF, 3'b000, rd, err, cyc, srdy);
        check_val("below_priv_slverr", {31'd0, err}, 32'd0);
        check_val("prdata_hold", rd, 32'h12345678);
        go_idle("below_priv_idle");
        apb_xfer(1'b0, 32'hE0, 32'h0, 4'h0, 3'b000, rd, err, cyc, srdy);
        check_val("unpriv_rd_slverr", {31'd0, err}, 32'd1);
        check_val("unpriv_rd_prdata", rd, 32'h0);
        go_idle("unpriv_rd_idle");

        // Abort a write to 0x20 in its second access cycle
        apb_xfer(1'b1, 32'h20, 32'h600DCAFE, 4'hF, 3'b001, rd, err, cyc, srdy);
        go_idle("abort_pre_idle");
        @(posedge PCLK); #1;
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1;
        m_paddr = 32'h20; m_pwdata = 32'hBAD0BAD0; m_pstrb = 4'hF; m_pprot = 3'b001;
        @(posedge PCLK); #1;
        m_penable = 1'b1;
        check_val("abort_acc1_pready", {31'd0, s_pready}, 32'd0);
        @(posedge PCLK); #1;
        m_psel = 1'b0; m_penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge PCLK); #1;
            check_val("abort_no_pready", {31'd0, s_pready}, 32'd0);
        end
        apb_xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, err, cyc, srdy);
        check_val("abort_mem_unchanged", rd, 32'h600DCAFE);
        check_val("abort_next_latency", cyc, 32'd3);
        go_idle("abort_post_idle");

        // Zero wait states, back-to-back alternating write/read
        sel0 = 1'b1;
        apb_xfer(1'b1, 32'h04, 32'h0BADF00D, 4'hF, 3'b001, rd, err, cyc, srdy);
        check_val("ws0_wr1_latency", cyc, 32'd1);
        apb_xfer(1'b0, 32'h04, 32'h0, 4'h0, 3'b001, rd, err, cyc, srdy);
        check_val("ws0_rd1_setup_low", {31'd0, srdy}, 32'd0);
        check_val("ws0_rd1_latency", cyc, 32'd1);
        check_val("ws0_rd1_data", rd, 32'h0BADF00D);
        apb_xfer(1'b1, 32'h08, 32'h13579BDF, 4'hF, 3'b001, rd, err, cyc, srdy);
        check_val("ws0_wr2_setup_low", {31'd0, srdy}, 32'd0);
        check_val("ws0_wr2_latency", cyc, 32'd1);
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, err, cyc, srdy);
        check_val("ws0_rd2_setup_low", {31'd0, srdy}, 32'd0);
        check_val("ws0_rd2_latency", cyc, 32'd1);
        check_val("ws0_rd2_data", rd, 32'h13579BDF);
        check_val("ws0_rd2_slverr", {31'd0, err}, 32'd0);
        go_idle("ws0_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
